// File: rtl/cpu_pkg.sv
// Shared datapath constants: operand source indices and skid-buffer state encoding.
package cpu_pkg;

  // Operand source indices as seen on the flattened data_i bus.
  localparam int SRC_RF    = 0;
  localparam int SRC_EXMEM = 1;
  localparam int SRC_MEMWB = 2;
  localparam int SRC_IMM   = 3;

  // Occupancy of the 2-entry skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage : cpu_pkg

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: main register feeds the output, the skid register
// catches the one beat that can arrive while ready_o is being withdrawn.
module pipe_skid_reg
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             accept_o
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             accept_s;
  logic             pop_s;

  // Next-state, buffer moves and registered handshake outputs.
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    accept_s = in_valid_i && ready_q && !flush_i;
    pop_s    = valid_q && out_ready_i;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d = ST_ONE;
            main_d  = in_data_i;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && !pop_s) begin
            state_d = ST_FULL;
            skid_d  = in_data_i;
          end else if (accept_s && pop_s) begin
            state_d = ST_ONE;
            main_d  = in_data_i;
          end else if (pop_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (pop_s) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
    ready_d = (state_d != ST_FULL);
    valid_d = (state_d != ST_EMPTY);
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= {WIDTH{1'b0}};
      skid_q  <= {WIDTH{1'b0}};
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = main_q;
  assign accept_o    = accept_s;

endmodule : pipe_skid_reg

// File: rtl/operand_sel_stage.sv
// Operand-select stage: N_SRC-way operand mux with range check, registered
// behind a valid/ready skid buffer in front of the ALU.
module operand_sel_stage
  import cpu_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N_SRC = 4,
  localparam int SEL_W = $clog2(N_SRC)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_SRC*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]       select_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   flush_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   sel_err_o
);

  logic             sel_bad_s;
  logic [SEL_W-1:0] sel_idx_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             accept_s;
  logic             sel_err_q, sel_err_d;

  // Out-of-range selects fall back to the register-file source.
  always_comb begin
    sel_bad_s = (32'(select_i) >= 32'(N_SRC));
    if (sel_bad_s) begin
      sel_idx_s = SEL_W'(SRC_RF);
    end else begin
      sel_idx_s = select_i;
    end
    sel_data_s = data_i[sel_idx_s*WIDTH +: WIDTH];
    sel_err_d  = accept_s && sel_bad_s;
  end

  pipe_skid_reg #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   (sel_data_s),
    .in_valid_i  (valid_i),
    .in_ready_o  (ready_o),
    .flush_i     (flush_i),
    .out_data_o  (data_o),
    .out_valid_o (valid_o),
    .out_ready_i (ready_i),
    .accept_o    (accept_s)
  );

  // Select-error pulse for the beat accepted on the previous edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err_o = sel_err_q;

endmodule : operand_sel_stage

// File: tb/tb_operand_sel_stage.sv
// Directed bench: a 4-source instance for select/backpressure/flush/reset and
// a 3-source instance for out-of-range select behaviour.
module tb_operand_sel_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // 4-source instance
  logic [127:0] d4;
  logic [1:0]   sel4;
  logic         v4, f4, r4;
  logic         rdy4, vo4, err4;
  logic [31:0]  q4;

  // 3-source instance
  logic [95:0]  d3;
  logic [1:0]   sel3;
  logic         v3, f3, r3;
  logic         rdy3, vo3, err3;
  logic [31:0]  q3;

  always #5 clk = ~clk;

  operand_sel_stage #(.WIDTH(32), .N_SRC(4)) u4 (
    .clk_i(clk), .rst_i(rst), .data_i(d4), .select_i(sel4), .valid_i(v4),
    .ready_o(rdy4), .flush_i(f4), .data_o(q4), .valid_o(vo4),
    .ready_i(r4), .sel_err_o(err4)
  );

  operand_sel_stage #(.WIDTH(32), .N_SRC(3)) u3 (
    .clk_i(clk), .rst_i(rst), .data_i(d3), .select_i(sel3), .valid_i(v3),
    .ready_o(rdy3), .flush_i(f3), .data_o(q3), .valid_o(vo3),
    .ready_i(r3), .sel_err_o(err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic v, input logic [31:0] d,
                      input logic rdy, input logic e);
    chk({tag, ".valid"}, {31'd0, vo4}, {31'd0, v});
    chk({tag, ".data"}, q4, d);
    chk({tag, ".ready"}, {31'd0, rdy4}, {31'd0, rdy});
    chk({tag, ".sel_err"}, {31'd0, err4}, {31'd0, e});
  endtask

  logic [31:0] sweep_exp [4];

  initial begin
    d4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    d3 = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    sweep_exp[0] = 32'h11111111;
    sweep_exp[1] = 32'h22222222;
    sweep_exp[2] = 32'h33333333;
    sweep_exp[3] = 32'h44444444;
    sel4 = 2'd1; v4 = 1'b1; f4 = 1'b0; r4 = 1'b1;
    sel3 = 2'd0; v3 = 1'b1; f3 = 1'b0; r3 = 1'b1;
    rst = 1'b0;

    // 1: reset held two edges with valid offered
    tick;
    chk4("rst_c1", 1'b0, 32'h0, 1'b1, 1'b0);
    chk("rst_c1.u3valid", {31'd0, vo3}, 32'd0);
    tick;
    chk4("rst_c2", 1'b0, 32'h0, 1'b1, 1'b0);
    chk("rst_c2.u3data", q3, 32'h0);
    v3 = 1'b0;
    rst = 1'b1;
    tick;
    chk4("rst_release", 1'b1, 32'h22222222, 1'b1, 1'b0);

    // 2: select sweep, back-to-back with ready_i high
    for (int k = 0; k < 4; k++) begin
      sel4 = 2'(k);
      tick;
      chk4($sformatf("sweep%0d", k), 1'b1, sweep_exp[k], 1'b1, 1'b0);
    end
    v4 = 1'b0;
    tick;
    chk4("drain", 1'b0, 32'h44444444, 1'b1, 1'b0);

    // 3: backpressure, three beats offered
    r4 = 1'b0; v4 = 1'b1; sel4 = 2'd0;
    tick;
    chk4("bp_a", 1'b1, 32'h11111111, 1'b1, 1'b0);
    sel4 = 2'd1;
    tick;
    chk4("bp_b", 1'b1, 32'h11111111, 1'b0, 1'b0);
    sel4 = 2'd2;
    tick;
    chk4("bp_c_blocked", 1'b1, 32'h11111111, 1'b0, 1'b0);
    r4 = 1'b1;
    tick;
    chk4("bp_pop_a", 1'b1, 32'h22222222, 1'b1, 1'b0);
    tick;
    chk4("bp_pop_b", 1'b1, 32'h33333333, 1'b1, 1'b0);
    v4 = 1'b0;
    tick;
    chk4("bp_pop_c", 1'b0, 32'h33333333, 1'b1, 1'b0);

    // 4: flush while FULL with a beat offered
    r4 = 1'b0; v4 = 1'b1; sel4 = 2'd0;
    tick;
    sel4 = 2'd1;
    tick;
    chk4("fl_full", 1'b1, 32'h11111111, 1'b0, 1'b0);
    f4 = 1'b1; sel4 = 2'd3;
    tick;
    chk4("fl_cycle", 1'b0, 32'h11111111, 1'b1, 1'b0);
    f4 = 1'b0; v4 = 1'b0; r4 = 1'b1;
    tick;
    chk4("fl_after", 1'b0, 32'h11111111, 1'b1, 1'b0);
    tick;
    chk4("fl_after2", 1'b0, 32'h11111111, 1'b1, 1'b0);

    // 5: out-of-range select on the 3-source instance
    v3 = 1'b1; sel3 = 2'd3; r3 = 1'b1;
    tick;
    chk("bad.data", q3, 32'hAAAAAAAA);
    chk("bad.valid", {31'd0, vo3}, 32'd1);
    chk("bad.err", {31'd0, err3}, 32'd1);
    v3 = 1'b0;
    tick;
    chk("bad.err_once", {31'd0, err3}, 32'd0);
    v3 = 1'b1; f3 = 1'b1;
    tick;
    chk("bad.flush_err", {31'd0, err3}, 32'd0);
    chk("bad.flush_valid", {31'd0, vo3}, 32'd0);
    f3 = 1'b0; r3 = 1'b0; sel3 = 2'd1;
    tick;
    chk("good.data", q3, 32'hBBBBBBBB);
    chk("good.err", {31'd0, err3}, 32'd0);
    sel3 = 2'd2;
    tick;
    chk("u3.full_ready", {31'd0, rdy3}, 32'd0);
    sel3 = 2'd3;
    tick;
    chk("bad.blocked_err", {31'd0, err3}, 32'd0);
    chk("bad.blocked_data", q3, 32'hBBBBBBBB);
    v3 = 1'b0;

    // 6: reset while FULL under backpressure
    r4 = 1'b0; v4 = 1'b1; sel4 = 2'd2;
    tick;
    sel4 = 2'd3;
    tick;
    chk4("mr_full", 1'b1, 32'h33333333, 1'b0, 1'b0);
    rst = 1'b0; v4 = 1'b0;
    tick;
    chk4("mr_reset", 1'b0, 32'h0, 1'b1, 1'b0);
    rst = 1'b1; r4 = 1'b1;
    tick;
    chk4("mr_rel1", 1'b0, 32'h0, 1'b1, 1'b0);
    tick;
    chk4("mr_rel2", 1'b0, 32'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_operand_sel_stage
